// File: rtl/route_pkg.sv
// Shared definitions for the route lookup engine: entry field layout, the compare key
// presented to the best-match reduction, and the registered response record.
package route_pkg;

  localparam int unsigned ENTRY_WIDTH = 256;
  localparam int unsigned IP_WIDTH    = 32;
  localparam int unsigned IDX_WIDTH   = 6;
  localparam int unsigned PORT_WIDTH  = 16;
  localparam int unsigned MAC_WIDTH   = 48;
  localparam int unsigned PLEN_WIDTH  = 6;

  localparam int unsigned DST_IP_LSB   = 0;
  localparam int unsigned MASK_LSB     = 32;
  localparam int unsigned OUT_PORT_LSB = 64;
  localparam int unsigned OUT_QP_LSB   = 80;
  localparam int unsigned NH_IP_LSB    = 96;
  localparam int unsigned NH_PORT_LSB  = 128;
  localparam int unsigned NH_QP_LSB    = 144;
  localparam int unsigned NH_MAC_LSB   = 160;
  localparam int unsigned VALID_BIT    = 208;
  localparam int unsigned DIRECT_BIT   = 209;
  localparam int unsigned BCAST_BIT    = 210;
  localparam int unsigned PLEN_LSB     = 211;

  // Bits above the prefix length are reserved and never stored.
  localparam int unsigned STORE_WIDTH = PLEN_LSB + PLEN_WIDTH;

  typedef logic [STORE_WIDTH-1:0] entry_t;

  typedef struct packed {
    logic [PLEN_WIDTH-1:0] plen;
    logic                  valid;
    logic [IP_WIDTH-1:0]   mask;
    logic [IP_WIDTH-1:0]   dst;
  } key_t;

  typedef struct packed {
    logic                  found;
    logic [PORT_WIDTH-1:0] out_port;
    logic [PORT_WIDTH-1:0] out_qp;
    logic [IP_WIDTH-1:0]   nh_ip;
    logic [PORT_WIDTH-1:0] nh_port;
    logic [PORT_WIDTH-1:0] nh_qp;
    logic [MAC_WIDTH-1:0]  nh_mac;
    logic                  is_direct;
    logic                  is_bcast;
  } resp_t;

  function automatic key_t entry_to_key(input entry_t e, input logic written);
    key_t k;
    k.plen  = e[PLEN_LSB +: PLEN_WIDTH];
    k.valid = e[VALID_BIT] & written;
    k.mask  = e[MASK_LSB +: IP_WIDTH];
    k.dst   = e[DST_IP_LSB +: IP_WIDTH];
    return k;
  endfunction

  function automatic resp_t entry_to_resp(input entry_t e);
    resp_t r;
    r.found     = 1'b1;
    r.out_port  = e[OUT_PORT_LSB +: PORT_WIDTH];
    r.out_qp    = e[OUT_QP_LSB +: PORT_WIDTH];
    r.nh_ip     = e[NH_IP_LSB +: IP_WIDTH];
    r.nh_port   = e[NH_PORT_LSB +: PORT_WIDTH];
    r.nh_qp     = e[NH_QP_LSB +: PORT_WIDTH];
    r.nh_mac    = e[NH_MAC_LSB +: MAC_WIDTH];
    r.is_direct = e[DIRECT_BIT];
    r.is_bcast  = e[BCAST_BIT];
    return r;
  endfunction

endpackage

// File: rtl/route_best_match.sv
// Parallel masked compare of one destination IP against every table key, reduced to the
// longest matching prefix; ties resolve to the lowest slot index.
module route_best_match
  import route_pkg::*;
#(
  parameter int unsigned MAX_ENTRIES = 64
) (
  input  logic [IP_WIDTH-1:0]  lookup_ip_i,
  input  key_t                 keys_i [MAX_ENTRIES],
  output logic                 hit_o,
  output logic [IDX_WIDTH-1:0] idx_o
);

  logic [MAX_ENTRIES-1:0] match;
  logic [PLEN_WIDTH-1:0]  best_len;

  always_comb begin
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      match[i] = keys_i[i].valid &&
                 (((lookup_ip_i ^ keys_i[i].dst) & keys_i[i].mask) == '0);
    end
  end

  // Strictly-greater update while scanning upward keeps the lowest index on a tie.
  always_comb begin
    hit_o    = 1'b0;
    idx_o    = '0;
    best_len = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (match[i] && (!hit_o || keys_i[i].plen > best_len)) begin
        hit_o    = 1'b1;
        idx_o    = IDX_WIDTH'(i);
        best_len = keys_i[i].plen;
      end
    end
  end

endmodule

// File: rtl/route_lookup_engine.sv
// Routing table with init-mode loading and a 2-stage longest-prefix lookup pipeline:
// stage 1 registers the winning slot, stage 2 registers that slot's fields onto resp_*.
module route_lookup_engine
  import route_pkg::*;
#(
  parameter int unsigned MAX_ENTRIES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_mode,
  input  logic [ENTRY_WIDTH-1:0] init_entry_data,
  input  logic [IDX_WIDTH-1:0]   init_entry_addr,
  input  logic                   init_entry_wr,
  input  logic                   lookup_valid,
  input  logic [IP_WIDTH-1:0]    lookup_dst_ip,
  output logic                   resp_valid,
  output logic                   resp_found,
  output logic [PORT_WIDTH-1:0]  resp_out_port,
  output logic [PORT_WIDTH-1:0]  resp_out_qp,
  output logic [IP_WIDTH-1:0]    resp_next_hop_ip,
  output logic [PORT_WIDTH-1:0]  resp_next_hop_port,
  output logic [PORT_WIDTH-1:0]  resp_next_hop_qp,
  output logic [MAC_WIDTH-1:0]   resp_next_hop_mac,
  output logic                   resp_is_direct_host,
  output logic                   resp_is_broadcast
);

  entry_t                 entry_q [MAX_ENTRIES];
  entry_t                 entry_d [MAX_ENTRIES];
  logic [MAX_ENTRIES-1:0] written_q, written_d;
  key_t                   keys [MAX_ENTRIES];
  logic                   match_hit;
  logic [IDX_WIDTH-1:0]   match_idx;

  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_hit_q, s1_hit_d;
  logic [IDX_WIDTH-1:0]   s1_idx_q, s1_idx_d;
  entry_t                 sel_entry;
  logic                   resp_valid_q, resp_valid_d;
  resp_t                  resp_q, resp_d;

  logic unused_reserved;
  assign unused_reserved = ^init_entry_data[ENTRY_WIDTH-1:STORE_WIDTH];

  // Out-of-range addresses decode to no slot, so those writes fall away naturally.
  always_comb begin
    entry_d   = entry_q;
    written_d = written_q;
    if (init_mode && init_entry_wr) begin
      for (int i = 0; i < MAX_ENTRIES; i++) begin
        if (init_entry_addr == IDX_WIDTH'(i)) begin
          entry_d[i]   = init_entry_data[STORE_WIDTH-1:0];
          written_d[i] = 1'b1;
        end
      end
    end
  end

  // Slot payload needs no reset; the per-slot written flag gates the stored valid bit.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q <= '0;
    end else begin
      written_q <= written_d;
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      keys[i] = entry_to_key(entry_q[i], written_q[i]);
    end
  end

  route_best_match #(
    .MAX_ENTRIES(MAX_ENTRIES)
  ) u_best_match (
    .lookup_ip_i(lookup_dst_ip),
    .keys_i     (keys),
    .hit_o      (match_hit),
    .idx_o      (match_idx)
  );

  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (s1_idx_q == IDX_WIDTH'(i)) begin
        sel_entry = entry_q[i];
      end
    end
  end

  always_comb begin
    s1_valid_d = lookup_valid & ~init_mode;
    s1_hit_d   = s1_hit_q;
    s1_idx_d   = s1_idx_q;
    if (s1_valid_d) begin
      s1_hit_d = match_hit;
      s1_idx_d = match_idx;
    end
    resp_valid_d = s1_valid_q;
    resp_d       = resp_q;
    if (s1_valid_q) begin
      resp_d = s1_hit_q ? entry_to_resp(sel_entry) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_hit_q     <= 1'b0;
      s1_idx_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_hit_q     <= s1_hit_d;
      s1_idx_q     <= s1_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  assign resp_valid          = resp_valid_q;
  assign resp_found          = resp_q.found;
  assign resp_out_port       = resp_q.out_port;
  assign resp_out_qp         = resp_q.out_qp;
  assign resp_next_hop_ip    = resp_q.nh_ip;
  assign resp_next_hop_port  = resp_q.nh_port;
  assign resp_next_hop_qp    = resp_q.nh_qp;
  assign resp_next_hop_mac   = resp_q.nh_mac;
  assign resp_is_direct_host = resp_q.is_direct;
  assign resp_is_broadcast   = resp_q.is_bcast;

endmodule

// File: tb/tb_route_lookup_engine.sv
// Scoreboard bench for route_lookup_engine: directed scenarios then randomized writes and
// lookups, each response checked against a longest-prefix reference model.
module tb_route_lookup_engine;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init_mode = 1'b0;
  logic [255:0] init_entry_data = '0;
  logic [5:0]   init_entry_addr = '0;
  logic         init_entry_wr = 1'b0;
  logic         lookup_valid = 1'b0;
  logic [31:0]  lookup_dst_ip = '0;
  logic         resp_valid, resp_found, resp_is_direct_host, resp_is_broadcast;
  logic [15:0]  resp_out_port, resp_out_qp, resp_next_hop_port, resp_next_hop_qp;
  logic [31:0]  resp_next_hop_ip;
  logic [47:0]  resp_next_hop_mac;

  route_lookup_engine #(.MAX_ENTRIES(N)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .init_mode          (init_mode),
    .init_entry_data    (init_entry_data),
    .init_entry_addr    (init_entry_addr),
    .init_entry_wr      (init_entry_wr),
    .lookup_valid       (lookup_valid),
    .lookup_dst_ip      (lookup_dst_ip),
    .resp_valid         (resp_valid),
    .resp_found         (resp_found),
    .resp_out_port      (resp_out_port),
    .resp_out_qp        (resp_out_qp),
    .resp_next_hop_ip   (resp_next_hop_ip),
    .resp_next_hop_port (resp_next_hop_port),
    .resp_next_hop_qp   (resp_next_hop_qp),
    .resp_next_hop_mac  (resp_next_hop_mac),
    .resp_is_direct_host(resp_is_direct_host),
    .resp_is_broadcast  (resp_is_broadcast)
  );

  typedef struct packed {
    logic        found;
    logic [15:0] out_port;
    logic [15:0] out_qp;
    logic [31:0] nh_ip;
    logic [15:0] nh_port;
    logic [15:0] nh_qp;
    logic [47:0] mac;
    logic        direct;
    logic        bcast;
  } rsp_t;

  rsp_t         exp_q[$];
  int           cyc_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  logic [255:0] m_tab [N];
  bit           m_wr [N];
  rsp_t         act, mon_exp;
  int           mon_cyc;

  assign act = {resp_found, resp_out_port, resp_out_qp, resp_next_hop_ip, resp_next_hop_port,
                resp_next_hop_qp, resp_next_hop_mac, resp_is_direct_host, resp_is_broadcast};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] plen2mask(input int plen);
    if (plen == 0) return 32'h0;
    return 32'hFFFF_FFFF << (32 - plen);
  endfunction

  // Reference: scan every written, valid slot; keep the longest prefix, first one on a tie.
  function automatic rsp_t model_lookup(input logic [31:0] ip);
    rsp_t         r = '0;
    int           best = -1;
    int           best_len = -1;
    logic [255:0] e;
    for (int i = 0; i < N; i++) begin
      e = m_tab[i];
      if (m_wr[i] && e[208] && ((ip & e[63:32]) == (e[31:0] & e[63:32])) &&
          int'(e[216:211]) > best_len) begin
        best     = i;
        best_len = int'(e[216:211]);
      end
    end
    if (best >= 0) begin
      e          = m_tab[best];
      r.found    = 1'b1;
      r.out_port = e[79:64];
      r.out_qp   = e[95:80];
      r.nh_ip    = e[127:96];
      r.nh_port  = e[143:128];
      r.nh_qp    = e[159:144];
      r.mac      = e[207:160];
      r.direct   = e[209];
      r.bcast    = e[210];
    end
    return r;
  endfunction

  function automatic logic [255:0] mk(input logic [31:0] dst, input int plen,
                                      input logic [15:0] oport, input logic [47:0] mac,
                                      input logic v, input logic d, input logic b);
    logic [255:0] e;
    for (int i = 0; i < 8; i++) e[i*32 +: 32] = $urandom();
    e[31:0]    = dst;
    e[63:32]   = plen2mask(plen);
    e[79:64]   = oport;
    e[207:160] = mac;
    e[208]     = v;
    e[209]     = d;
    e[210]     = b;
    e[216:211] = 6'(plen);
    return e;
  endfunction

  function automatic logic [31:0] rand_ip();
    if ($urandom_range(0, 9) == 0) return $urandom();
    return {8'd10, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_zero(input string name);
    @(negedge clk);
    vectors++;
    if ({resp_valid, act} !== '0) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b resp=%h, required all zero", name, resp_valid, act);
    end
  endtask

  task automatic write(input logic mode, input logic [5:0] addr, input logic [255:0] data);
    init_mode       = mode;
    init_entry_wr   = 1'b1;
    init_entry_addr = addr;
    init_entry_data = data;
    if (mode && int'(addr) < N) begin
      m_tab[addr] = data;
      m_wr[addr]  = 1'b1;
    end
    tick();
    init_entry_wr = 1'b0;
  endtask

  task automatic lookup(input logic mode, input logic [31:0] ip);
    init_mode     = mode;
    lookup_valid  = 1'b1;
    lookup_dst_ip = ip;
    if (!mode) begin
      exp_q.push_back(model_lookup(ip));
      cyc_q.push_back(cyc + 2);
    end
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    lookup_valid  = 1'b0;
    init_entry_wr = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    for (int i = 0; i < N; i++) m_wr[i] = 1'b0;
    check_zero("reset_outputs");
    idle(2);
    rst_n = 1'b1;
    tick();
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = cyc_q.pop_front();
        if (act !== mon_exp) begin
          miscompares++;
          $display("FAIL resp: got %h, required %h", act, mon_exp);
        end
        vectors++;
        if (cyc != mon_cyc) begin
          miscompares++;
          $display("FAIL latency: got response at cycle %0d, required %0d", cyc, mon_cyc);
        end
      end
    end
  end

  initial begin
    do_reset();
    lookup(1'b0, 32'h0A00_0001);
    idle(3);

    write(1'b1, 6'd0, mk(32'h0A00_0000, 24, 16'd3, 48'h0A0B_0C0D_0E0F, 1'b1, 1'b1, 1'b0));
    lookup(1'b0, 32'h0A00_0007);
    idle(3);

    do_reset();
    write(1'b1, 6'd1, mk(32'h0A00_0000, 8, 16'd5, 48'h1111_2222_3333, 1'b1, 1'b0, 1'b0));
    write(1'b1, 6'd2, mk(32'h0A00_0000, 24, 16'd7, 48'h4444_5555_6666, 1'b1, 1'b0, 1'b0));
    lookup(1'b0, 32'h0A00_0009);
    lookup(1'b0, 32'h0A01_0203);
    idle(3);

    lookup(1'b0, 32'h0A00_0001);
    lookup(1'b0, 32'h0B00_0001);
    lookup(1'b0, 32'h0A02_0000);
    lookup(1'b0, 32'hC0A8_0101);
    idle(3);

    write(1'b0, 6'd3, mk(32'h1400_0000, 8, 16'd9, 48'h0, 1'b1, 1'b0, 1'b0));
    write(1'b1, 6'd63, mk(32'h1E00_0000, 8, 16'd9, 48'h0, 1'b1, 1'b0, 1'b0));
    lookup(1'b0, 32'h1401_0101);
    lookup(1'b0, 32'h1E01_0101);
    lookup(1'b1, 32'h0A00_0001);
    idle(4);

    write(1'b1, 6'd4, mk(32'hFFFF_FFFF, 32, 16'd9, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1));
    lookup(1'b0, 32'hFFFF_FFFF);
    idle(3);
    lookup(1'b0, 32'hFFFF_FFFF);
    do_reset();
    idle(4);

    repeat (400) begin
      if ($urandom_range(0, 99) < 25) begin
        write(1'($urandom_range(0, 9) != 0), 6'($urandom_range(0, 40)),
              mk(rand_ip(), int'($urandom_range(0, 32)), 16'($urandom()),
                 {16'($urandom()), 32'($urandom())}, 1'($urandom_range(0, 7) != 0),
                 1'($urandom()), 1'($urandom())));
      end else if ($urandom_range(0, 9) == 0) begin
        idle(1);
      end else begin
        lookup(1'($urandom_range(0, 9) == 0), rand_ip());
      end
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
